// File: rtl/mem_stage.sv
// MEM pipeline stage: issues load/store on the dmem req/ack bus and
// registers writeback parameters for WB; stalls upstream while busy.
module mem_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  rd_addr_in,
  input  logic [31:0] rd_data_in,
  input  logic [3:0]  mem_op_in,
  input  logic [31:0] mem_data_in,
  output logic        stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        wb_valid,
  output logic [4:0]  wb_rd_addr,
  output logic [31:0] wb_rd_data,
  output logic        misalign_exc,
  output logic        bus_err
);

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LBU = 4'd2;
  localparam logic [3:0] OP_LH  = 4'd3;
  localparam logic [3:0] OP_LHU = 4'd4;
  localparam logic [3:0] OP_LW  = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } bus_t;

  typedef struct packed {
    logic        valid;
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_t;

  state_t      state, state_nxt;
  logic [31:0] cnt, cnt_nxt;
  logic [3:0]  op_q;
  logic [1:0]  off_q;
  logic [4:0]  rd_q;
  bus_t        bus_q, bus_nxt;
  wb_t         wb_q, wb_nxt;
  logic        mis_q, mis_nxt;
  logic        berr_q, berr_nxt;

  logic        in_load, in_store, in_mem, misalign, issue;
  logic        ack_hit, timeout;
  logic [1:0]  in_size;
  logic [3:0]  be_in;
  logic [31:0] wdata_in;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] ld_data;
  logic        q_is_load;

  // size: 0 byte, 1 half, 2 word
  always_comb begin
    in_load  = 1'b0;
    in_store = 1'b0;
    in_size  = 2'd0;
    case (mem_op_in)
      OP_LB, OP_LBU: begin in_load  = 1'b1; in_size = 2'd0; end
      OP_LH, OP_LHU: begin in_load  = 1'b1; in_size = 2'd1; end
      OP_LW:         begin in_load  = 1'b1; in_size = 2'd2; end
      OP_SB:         begin in_store = 1'b1; in_size = 2'd0; end
      OP_SH:         begin in_store = 1'b1; in_size = 2'd1; end
      OP_SW:         begin in_store = 1'b1; in_size = 2'd2; end
      default: ;
    endcase
  end

  assign in_mem   = in_load | in_store;
  assign misalign = in_mem && ((in_size == 2'd1 && rd_data_in[0]) ||
                               (in_size == 2'd2 && rd_data_in[1:0] != 2'b00));
  assign issue    = (state == IDLE) && in_mem && !misalign;
  assign ack_hit  = (state == BUSY) && dmem_ack;
  // an ack in the final allowed cycle takes priority over the timeout
  assign timeout  = (state == BUSY) && !dmem_ack && (TIMEOUT_CYCLES != 0) &&
                    ((cnt + 32'd1) >= TIMEOUT_CYCLES);

  // gated by rst so a reset mid-access releases the pipeline without an edge
  assign stall = !rst && (issue || ((state == BUSY) && !dmem_ack && !timeout));

  always_comb begin
    be_in    = 4'b1111;
    wdata_in = mem_data_in;
    case (in_size)
      2'd0: begin
        be_in    = 4'b0001 << rd_data_in[1:0];
        wdata_in = {4{mem_data_in[7:0]}};
      end
      2'd1: begin
        be_in    = rd_data_in[1] ? 4'b1100 : 4'b0011;
        wdata_in = {2{mem_data_in[15:0]}};
      end
      default: ;
    endcase
    if (!in_store) wdata_in = 32'd0;
  end

  always_comb begin
    case (off_q)
      2'd0:    lane_b = dmem_rdata[7:0];
      2'd1:    lane_b = dmem_rdata[15:8];
      2'd2:    lane_b = dmem_rdata[23:16];
      default: lane_b = dmem_rdata[31:24];
    endcase
    lane_h = off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (op_q)
      OP_LB:   ld_data = {{24{lane_b[7]}}, lane_b};
      OP_LBU:  ld_data = {24'd0, lane_b};
      OP_LH:   ld_data = {{16{lane_h[15]}}, lane_h};
      OP_LHU:  ld_data = {16'd0, lane_h};
      default: ld_data = dmem_rdata;
    endcase
  end

  assign q_is_load = (op_q >= OP_LB) && (op_q <= OP_LW);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (issue) state_nxt = BUSY;
      BUSY:    if (ack_hit || timeout) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus_nxt  = bus_q;
    wb_nxt   = '0;
    mis_nxt  = 1'b0;
    berr_nxt = 1'b0;
    cnt_nxt  = cnt;
    case (state)
      IDLE: begin
        cnt_nxt = 32'd0;
        if (!in_mem)
          wb_nxt = '{valid: (rd_addr_in != 5'd0), rd: rd_addr_in, data: rd_data_in};
        else if (misalign)
          mis_nxt = 1'b1;
        else
          bus_nxt = '{req: 1'b1, we: in_store, addr: {rd_data_in[31:2], 2'b00},
                      be: be_in, wdata: wdata_in};
      end
      BUSY: begin
        if (ack_hit) begin
          bus_nxt = '0;
          cnt_nxt = 32'd0;
          if (q_is_load)
            wb_nxt = '{valid: (rd_q != 5'd0), rd: rd_q, data: ld_data};
        end else if (timeout) begin
          bus_nxt  = '0;
          cnt_nxt  = 32'd0;
          berr_nxt = 1'b1;
        end else if (cnt != '1) begin
          cnt_nxt = cnt + 32'd1;
        end
      end
      default: bus_nxt = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= 32'd0;
      op_q   <= 4'd0;
      off_q  <= 2'd0;
      rd_q   <= 5'd0;
      bus_q  <= '0;
      wb_q   <= '0;
      mis_q  <= 1'b0;
      berr_q <= 1'b0;
    end else begin
      cnt    <= cnt_nxt;
      bus_q  <= bus_nxt;
      wb_q   <= wb_nxt;
      mis_q  <= mis_nxt;
      berr_q <= berr_nxt;
      if (issue) begin
        op_q  <= mem_op_in;
        off_q <= rd_data_in[1:0];
        rd_q  <= rd_addr_in;
      end
    end
  end

  assign dmem_req     = bus_q.req;
  assign dmem_we      = bus_q.we;
  assign dmem_addr    = bus_q.addr;
  assign dmem_be      = bus_q.be;
  assign dmem_wdata   = bus_q.wdata;
  assign wb_valid     = wb_q.valid;
  assign wb_rd_addr   = wb_q.rd;
  assign wb_rd_data   = wb_q.data;
  assign misalign_exc = mis_q;
  assign bus_err      = berr_q;

endmodule
